cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller between the CPU byte port and the 24-bit word-organised main memory.
- It owns the memory's block interface (write-back, fetch, complete) and sequences line evictions and fills.
- It serves byte reads and writes to the CPU from an internal line store.
- It sits in place of direct CPU-to-memory access; the memory byte port is left unused.

Parameters:
- LINES, 256, number of cache lines (power of 2); index width IDX_W = log2(LINES).
- ADDR_W, 24, byte address width; tag width = ADDR_W - 2 - IDX_W (14 at defaults).

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_rd  in  1  read request, held until cpu_ready.
- cpu_wr  in  1  write request, held until cpu_ready.
- cpu_wdata  in  8  write byte.
- cpu_flush  in  1  flush request: write back all dirty lines; held until cpu_ready.
- cpu_rdata  out  8  read byte, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  block address to memory, low two bits always 0.
- mem_wdata  out  32  line data for write-back.
- mem_rdata  in  32  line data returned by fetch.
- mem_wrt_bck  out  1  write-back command.
- mem_fetch  out  1  fetch command.
- mem_cmplt  in  1  memory completion, sampled on the rising edge.

Behaviour:
- Address split:
  - tag = addr[ADDR_W-1 : IDX_W+2]
  - index = addr[IDX_W+1 : 2]
  - byte lane addr[1:0]: 00 selects [7:0], 01 [15:8], 10 [23:16], 11 [31:24].
- Storage:
  - valid[LINES] and dirty[LINES] are flops cleared by reset.
  - tag and data arrays are not reset.
- Reset, asynchronous: state=IDLE; cpu_ready, cpu_rdata, mem_addr, mem_wdata, mem_wrt_bck, mem_fetch = 0; all valid/dirty = 0; flush counter = 0. Any in-flight memory command is abandoned, with no partial line update.
- Request priority in IDLE: cpu_flush > cpu_rd > cpu_wr. The winning address and data are latched.
- States:
  - IDLE: no request -> stay. Flush -> FLUSH_SCAN with counter=0. rd/wr -> LOOKUP.
  - LOOKUP, hit (valid and tag match):
    - Read: load the selected byte into cpu_rdata.
    - Write: merge the byte into the line and set dirty.
    - Go to RESP.
  - LOOKUP, miss: if valid and dirty -> WB, otherwise -> FILL.
  - WB:
    - mem_wrt_bck=1, mem_addr={stored tag, index, 2'b00}, mem_wdata=line.
    - Held until mem_cmplt=1 is sampled; then command low on the next cycle.
    - Clear dirty; next state is FILL, or FLUSH_SCAN during a flush.
  - FILL:
    - mem_fetch=1, mem_addr={req tag, index, 2'b00}.
    - On sampled mem_cmplt: line=mem_rdata, tag=req tag, valid=1, dirty=0, then -> LOOKUP. The re-lookup hits, so a write miss merges there.
  - FLUSH_SCAN:
    - If line[counter] is valid and dirty -> WB with that line.
    - Otherwise, when counter=LINES-1 -> RESP; else counter+1.
    - After WB returns, the counter advances. The last index goes to RESP with no wrap.
  - RESP: cpu_ready=1 for exactly one cycle -> IDLE.
- Latency:
  - Hit: request sampled at edge 0, cpu_ready high in cycle 2 (3 cycles total).
  - Clean miss adds FILL (1 + memory cycles) plus a second LOOKUP.
  - Dirty miss additionally adds WB.
- Handshake:
  - The CPU drops its request on the edge where it samples cpu_ready=1.
  - Changes to CPU inputs between IDLE sampling and cpu_ready are ignored, because the request is latched.
- Commands:
  - mem_wrt_bck and mem_fetch are never high together.
  - Each is high from state entry until the cycle after mem_cmplt is sampled.
  - mem_cmplt outside WB/FILL is ignored.
- Valid-but-clean flush lines are left valid; flush invalidates nothing.

Decomposition:
- Package cache_pkg holds:
  - the state enum (IDLE, LOOKUP, WB, FILL, FLUSH_SCAN, RESP);
  - the byte-lane select/merge function;
  - the tag/index width constants derived from LINES/ADDR_W.
- One sub-module, cache_store: the tag/data arrays plus valid/dirty flops, with lookup read port, line write port and byte-merge write.

Test Plan:
- Cold read, rst_n pulsed, memory word at 0x000040 = 0xA1B2C3D4:
  - Read 0x000041 -> one fetch with mem_addr=0x000040, no wrt_bck, cpu_rdata=0xC3.
  - Repeat the read -> cpu_ready exactly 2 cycles after sampling, no memory command.
- Write hit: write 0x5A to 0x000042 after the fill above -> no memory command, line dirty; read 0x000042 returns 0x5A.
- Conflict miss: read 0x010040 (same index, new tag) -> wrt_bck at 0x000040 with mem_wdata=0xA15AC3D4 first, then fetch 0x010040; the two commands are never overlapped.
- Flush with dirty lines at index 3 and 200 -> exactly two wrt_bck commands in index order, then a single cpu_ready pulse; a following flush issues zero commands.
- rst_n asserted mid-FILL (mem_fetch=1) -> mem_fetch low immediately; a subsequent read of the same address misses and refetches.
- cpu_rd and cpu_wr high together on a hit line -> read performed, line stays clean and unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache.
// Geometry defaults, FSM states and byte-lane select/merge.
package cache_pkg;

  localparam int C_LINES  = 256;
  localparam int C_ADDR_W = 24;
  localparam int C_IDX_W  = $clog2(C_LINES);
  localparam int C_TAG_W  = C_ADDR_W - 2 - C_IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    FLUSH_SCAN,
    RESP
  } state_t;

  function automatic logic [7:0] lane_get(
    input logic [31:0] line,
    input logic [1:0]  sel
  );
    logic [7:0] b;
    unique case (sel)
      2'd0: b = line[7:0];
      2'd1: b = line[15:8];
      2'd2: b = line[23:16];
      default: b = line[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] lane_put(
    input logic [31:0] line,
    input logic [1:0]  sel,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = line;
    unique case (sel)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cache_if.sv
// CPU byte port and memory block port of the cache controller.
// slave = controller side, master = CPU/memory side.
interface cache_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W
);

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [7:0]        cpu_wdata;
  logic              cpu_flush;
  logic [7:0]        cpu_rdata;
  logic              cpu_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_wrt_bck;
  logic              mem_fetch;
  logic              mem_cmplt;

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr,
    input  cpu_wdata, cpu_flush,
    input  mem_rdata, mem_cmplt,
    output cpu_rdata, cpu_ready,
    output mem_addr, mem_wdata,
    output mem_wrt_bck, mem_fetch
  );

  modport master (
    output cpu_addr, cpu_rd, cpu_wr,
    output cpu_wdata, cpu_flush,
    output mem_rdata, mem_cmplt,
    input  cpu_rdata, cpu_ready,
    input  mem_addr, mem_wdata,
    input  mem_wrt_bck, mem_fetch
  );

endinterface

// File: rtl/cache_store.sv
// Line store: tag/data arrays (unreset) plus valid/dirty flops.
// One index serves lookup, fill, byte merge and dirty clear.
module cache_store
  import cache_pkg::*;
#(
  parameter int LINES = C_LINES,
  parameter int TAG_W = C_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(LINES)-1:0] idx,
  output logic                     valid,
  output logic                     dirty,
  output logic [TAG_W-1:0]         tag,
  output logic [31:0]              line,
  input  logic                     fill,
  input  logic [TAG_W-1:0]         fill_tag,
  input  logic [31:0]              fill_line,
  input  logic                     merge,
  input  logic [1:0]               lane,
  input  logic [7:0]               byte_data,
  input  logic                     clean
);

  logic [LINES-1:0] vld;
  logic [LINES-1:0] drt;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  assign valid = vld[idx];
  assign dirty = drt[idx];
  assign tag   = tags[idx];
  assign line  = data[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      drt <= '0;
    end else begin
      unique case (1'b1)
        fill: begin
          vld[idx] <= 1'b1;
          drt[idx] <= 1'b0;
        end
        merge: drt[idx] <= 1'b1;
        clean: drt[idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tags[idx] <= fill_tag;
      data[idx] <= fill_line;
    end else if (merge) begin
      data[idx] <= lane_put(data[idx], lane, byte_data);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller.
// Serves CPU bytes from the line store; sequences evictions, fills, flush.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES  = C_LINES,
  parameter int ADDR_W = C_ADDR_W
) (
  input logic   clk,
  input logic   rst_n,
  cache_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              req_wr;
  logic              flushing;
  logic [IDX_W-1:0]  cnt;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_lane;
  logic [IDX_W-1:0]  idx;

  logic              s_valid;
  logic              s_dirty;
  logic [TAG_W-1:0]  s_tag;
  logic [31:0]       s_line;

  logic              hit;
  logic              fill;
  logic              merge;
  logic              clean;
  logic              last;

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[IDX_W+1:2];
  assign req_lane = req_addr[1:0];
  assign idx      = flushing ? cnt : req_idx;

  assign hit   = s_valid && (s_tag == req_tag);
  assign fill  = (state == FILL) && bus.mem_cmplt;
  assign merge = (state == LOOKUP) && hit && req_wr;
  assign clean = (state == WB) && bus.mem_cmplt;
  assign last  = &cnt;

  cache_store #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .valid     (s_valid),
    .dirty     (s_dirty),
    .tag       (s_tag),
    .line      (s_line),
    .fill      (fill),
    .fill_tag  (req_tag),
    .fill_line (bus.mem_rdata),
    .merge     (merge),
    .lane      (req_lane),
    .byte_data (req_wdata),
    .clean     (clean)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_addr        <= '0;
      req_wdata       <= '0;
      req_wr          <= 1'b0;
      flushing        <= 1'b0;
      cnt             <= '0;
      bus.cpu_ready   <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_wrt_bck <= 1'b0;
      bus.mem_fetch   <= 1'b0;
    end else begin
      bus.cpu_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cpu_flush) begin
            flushing <= 1'b1;
            cnt      <= '0;
            state    <= FLUSH_SCAN;
          end else if (bus.cpu_rd || bus.cpu_wr) begin
            req_addr  <= bus.cpu_addr;
            req_wdata <= bus.cpu_wdata;
            req_wr    <= !bus.cpu_rd;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (!req_wr)
              bus.cpu_rdata <= lane_get(s_line, req_lane);
            bus.cpu_ready <= 1'b1;
            state         <= RESP;
          end else if (s_valid && s_dirty) begin
            bus.mem_wrt_bck <= 1'b1;
            bus.mem_addr    <= {s_tag, idx, 2'b00};
            bus.mem_wdata   <= s_line;
            state           <= WB;
          end else begin
            bus.mem_fetch <= 1'b1;
            bus.mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            state         <= FILL;
          end
        end
        WB: begin
          if (bus.mem_cmplt) begin
            bus.mem_wrt_bck <= 1'b0;
            if (!flushing) begin
              bus.mem_fetch <= 1'b1;
              bus.mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              state         <= FILL;
            end else if (last) begin
              flushing      <= 1'b0;
              bus.cpu_ready <= 1'b1;
              state         <= RESP;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= FLUSH_SCAN;
            end
          end
        end
        FILL: begin
          // the fill lands this edge; re-lookup next cycle then hits
          if (bus.mem_cmplt) begin
            bus.mem_fetch <= 1'b0;
            state         <= LOOKUP;
          end
        end
        FLUSH_SCAN: begin
          if (s_valid && s_dirty) begin
            bus.mem_wrt_bck <= 1'b1;
            bus.mem_addr    <= {s_tag, idx, 2'b00};
            bus.mem_wdata   <= s_line;
            state           <= WB;
          end else if (last) begin
            flushing      <= 1'b0;
            bus.cpu_ready <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a simple block-memory responder.
// Monitors memory commands and ready pulses; checks hand-computed values.
module tb_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_if #(.ADDR_W(24)) bus ();

  cache_ctrl #(
    .LINES  (256),
    .ADDR_W (24)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] init_mem [int];
  logic [31:0] mem [int];
  int dly;

  function automatic logic [31:0] rd_word(input int a);
    if (mem.exists(a)) return mem[a];
    if (init_mem.exists(a)) return init_mem[a];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bus.mem_cmplt = 1'b0;
      bus.mem_rdata = 32'h0;
      dly = 0;
    end else if (bus.mem_cmplt) begin
      bus.mem_cmplt = 1'b0;
    end else if (bus.mem_wrt_bck || bus.mem_fetch) begin
      if (dly == 2) begin
        dly = 0;
        if (bus.mem_wrt_bck)
          mem[int'(bus.mem_addr)] = bus.mem_wdata;
        else
          bus.mem_rdata = rd_word(int'(bus.mem_addr));
        bus.mem_cmplt = 1'b1;
      end else begin
        dly++;
      end
    end else begin
      dly = 0;
    end
  end

  int          ev_kind [$];
  logic [31:0] ev_addr [$];
  logic [31:0] ev_data [$];
  int          ovl_n = 0;
  int          rdy_n = 0;
  logic        prev_wb = 1'b0;
  logic        prev_fe = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_wrt_bck && !prev_wb) begin
      ev_kind.push_back(1);
      ev_addr.push_back(32'(bus.mem_addr));
      ev_data.push_back(bus.mem_wdata);
    end
    if (bus.mem_fetch && !prev_fe) begin
      ev_kind.push_back(2);
      ev_addr.push_back(32'(bus.mem_addr));
      ev_data.push_back(32'h0);
    end
    if (bus.mem_wrt_bck && bus.mem_fetch) ovl_n++;
    if (bus.cpu_ready) rdy_n++;
    prev_wb = bus.mem_wrt_bck;
    prev_fe = bus.mem_fetch;
  end

  int ev0;
  int rdy0;

  function automatic int n_ev();
    return ev_kind.size() - ev0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic rd, input logic wr, input logic fl,
                      input logic [23:0] addr, input logic [7:0] wd,
                      output logic [7:0] rdata, output int lat);
    ev0  = ev_kind.size();
    rdy0 = rdy_n;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_flush = fl;
    @(posedge clk);
    lat = 0;
    while (lat < 4000) begin
      @(negedge clk);
      if (bus.cpu_ready) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 4000) check("timeout", 32'd1, 32'd0);
    rdata = bus.cpu_rdata;
    @(posedge clk);
    #1;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_flush = 1'b0;
    lat = lat + 1;
  endtask

  logic [7:0] rd;
  int         lat;
  int         k;

  initial begin
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_flush = 1'b0;
    init_mem[32'h000040] = 32'hA1B2C3D4;
    init_mem[32'h010040] = 32'h11223344;
    init_mem[32'h000500] = 32'hCAFEBABE;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("rst_fetch", 32'(bus.mem_fetch), 32'd0);
    check("rst_wb",    32'(bus.mem_wrt_bck), 32'd0);
    check("rst_maddr", 32'(bus.mem_addr), 32'd0);
    check("rst_mwdata", bus.mem_wdata, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    xact(1, 0, 0, 24'h000041, 8'h00, rd, lat);
    check("cold_nev", n_ev(), 1);
    check("cold_kind", ev_kind[ev0], 2);
    check("cold_addr", ev_addr[ev0], 32'h000040);
    check("cold_rdata", 32'(rd), 32'hC3);

    xact(1, 0, 0, 24'h000041, 8'h00, rd, lat);
    check("hit_lat", lat, 2);
    check("hit_nev", n_ev(), 0);
    check("hit_rdata", 32'(rd), 32'hC3);

    xact(0, 1, 0, 24'h000042, 8'h5A, rd, lat);
    check("wr_nev", n_ev(), 0);
    check("wr_lat", lat, 2);
    xact(1, 0, 0, 24'h000042, 8'h00, rd, lat);
    check("wr_rdback", 32'(rd), 32'h5A);

    xact(1, 0, 0, 24'h010040, 8'h00, rd, lat);
    check("cfl_nev", n_ev(), 2);
    if (n_ev() == 2) begin
      check("cfl_k0", ev_kind[ev0], 1);
      check("cfl_a0", ev_addr[ev0], 32'h000040);
      check("cfl_d0", ev_data[ev0], 32'hA15AC3D4);
      check("cfl_k1", ev_kind[ev0+1], 2);
      check("cfl_a1", ev_addr[ev0+1], 32'h010040);
    end
    check("cfl_ovl", ovl_n, 0);
    check("cfl_rdata", 32'(rd), 32'h44);

    xact(0, 1, 0, 24'h00000C, 8'h77, rd, lat);
    xact(0, 1, 0, 24'h000321, 8'h88, rd, lat);
    xact(0, 0, 1, 24'h000000, 8'h00, rd, lat);
    idle(3);
    check("fl_nev", n_ev(), 2);
    if (n_ev() == 2) begin
      check("fl_k0", ev_kind[ev0], 1);
      check("fl_a0", ev_addr[ev0], 32'h00000C);
      check("fl_d0", ev_data[ev0], 32'h00000077);
      check("fl_k1", ev_kind[ev0+1], 1);
      check("fl_a1", ev_addr[ev0+1], 32'h000320);
      check("fl_d1", ev_data[ev0+1], 32'h00008800);
    end
    check("fl_ready_n", rdy_n - rdy0, 1);
    check("fl_ovl", ovl_n, 0);
    xact(0, 0, 1, 24'h000000, 8'h00, rd, lat);
    check("fl2_nev", n_ev(), 0);

    bus.cpu_addr = 24'h000500;
    bus.cpu_rd   = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (bus.mem_fetch) break;
      k++;
    end
    check("mid_fetch_seen", 32'(bus.mem_fetch), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fetch", 32'(bus.mem_fetch), 32'd0);
    bus.cpu_rd = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    xact(1, 0, 0, 24'h000500, 8'h00, rd, lat);
    check("refetch_nev", n_ev(), 1);
    if (n_ev() == 1) begin
      check("refetch_kind", ev_kind[ev0], 2);
      check("refetch_addr", ev_addr[ev0], 32'h000500);
    end
    check("refetch_rdata", 32'(rd), 32'hBE);

    xact(1, 1, 0, 24'h000501, 8'hEE, rd, lat);
    check("rdwr_nev", n_ev(), 0);
    check("rdwr_rdata", 32'(rd), 32'hBA);
    xact(0, 0, 1, 24'h000000, 8'h00, rd, lat);
    check("rdwr_clean", n_ev(), 0);
    xact(1, 0, 0, 24'h000501, 8'h00, rd, lat);
    check("rdwr_keep", 32'(rd), 32'hBA);
    check("rdwr_lat", lat, 2);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
